divider_seq: RTL
================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have is_signed  input  1  1 = two's-complement divide (DIV), 0 = unsigned divide (DIVU).
REQ-006 SHALL have dividend  input  WIDTH  numerator; captured on the accepted start.
REQ-007 SHALL have divisor  input  WIDTH  denominator; captured on the accepted start.
REQ-008 SHALL have busy  output  1  high while a division is in progress.
REQ-009 SHALL have done  output  1  one-cycle pulse when q/r become valid.
REQ-010 SHALL have q  output  WIDTH  quotient.
REQ-011 SHALL have r  output  WIDTH  remainder.
REQ-012 SHALL have dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 SHALL implement states IDLE, CALC, FIN; IDLE->CALC on start, CALC->FIN after WIDTH iterations, FIN->IDLE unconditionally.
REQ-014 SHALL capture operands, is_signed and the operand signs on the clk edge where start=1 in IDLE; later input changes SHALL NOT affect the result.
REQ-015 SHALL in signed mode convert both operands to magnitudes before iterating; |0x80000000| is the unsigned value 0x80000000.
REQ-016 SHALL perform one restoring step per CALC cycle: shift partial remainder left 1 bit, take in the next dividend bit (MSB first), do a WIDTH+1-bit trial subtract of the divisor magnitude, keep the result if non-negative, and shift the quotient bit in.
REQ-017 SHALL assert busy from the cycle after start acceptance through the FIN cycle inclusive; WIDTH+1 cycles total.
REQ-018 SHALL pulse done for exactly the FIN cycle, i.e. WIDTH+1 cycles after the accepting edge; q, r and dz SHALL be valid in that cycle.
REQ-019 SHALL hold q, r and dz stable from FIN until the next accepted start.
REQ-020 SHALL in signed mode truncate toward zero: negate q when the operand signs differ, and give r the sign of the dividend.
REQ-021 SHALL for signed 0x80000000 / 0xFFFFFFFF return q=0x80000000, r=0, with no trap or flag.
REQ-022 SHALL for divisor==0 still take the full latency and return dz=1, q=all ones, r=dividend, in both modes.
REQ-023 SHALL ignore start while busy=1; an operation in progress SHALL NOT be restarted or corrupted.
REQ-024 SHALL accept a start in the cycle immediately after FIN (back-to-back operation).

Reset
REQ-025 SHALL on reset=1 at any clk edge, including mid-CALC, enter IDLE and clear busy, done, q, r, dz and all internal registers to 0.
REQ-026 SHALL ignore start in a cycle where reset=1.

Structure
REQ-027 SHALL take state encodings (IDLE, CALC, FIN) and the iteration-counter width (log2 WIDTH + 1) from the shared CPU package.
REQ-028 SHALL place one restoring iteration (shift, trial subtract, select) in sub-module div_step; divider_seq SHALL hold the FSM, counter, sign handling and output registers.

Verification
REQ-029 SHALL cover unsigned 100 / 7: start at edge N -> done at edge N+33, q=14, r=2, dz=0, busy high for 33 cycles.
REQ-030 SHALL cover signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> q=0xFFFFFFFD, r=0xFFFFFFFF; unsigned 0xFFFFFFF9 / 2 -> q=0x7FFFFFFC, r=1.
REQ-031 SHALL cover divide by zero 0x12345678 / 0 -> done at N+33, dz=1, q=0xFFFFFFFF, r=0x12345678.
REQ-032 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dz=0.
REQ-033 SHALL cover start re-asserted with new operands at cycle N+10 -> ignored, first result unchanged, done pulses once; then a start at N+34 -> a second valid result at N+67.
REQ-034 SHALL cover reset at cycle N+15 -> busy=0, done=0, q=r=0 on the next edge, and no done pulse at N+33.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential divider:
// FSM encodings and iteration-counter sizing.
package divider_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/divider_seq_step.sv
// One restoring division iteration: shift in the next
// dividend bit, trial subtract, keep or restore.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] sh;
  logic [W:0] diff;

  assign sh    = {rem_i, quo_i[W-1]};
  assign diff  = sh - {1'b0, dvs_i};
  assign rem_o = diff[W] ? sh[W-1:0] : diff[W-1:0];
  assign quo_o = {quo_i[W-2:0], ~diff[W]};

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider (DIV/DIVU), one
// quotient bit per cycle, WIDTH+1 cycles per result.
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] rem_n, quo_n;
  logic             a_neg, b_neg, last;

  div_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign last  = (state_q == S_CALC) &&
                 (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (last)  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FIN);
    q    = q_q;
    r    = r_q;
    dz   = dz_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    zero_d = zero_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = a_neg ? -dividend : dividend;
          dvs_d  = b_neg ? -divisor : divisor;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          zero_d = (divisor == '0);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = rem_n;
        quo_d = quo_n;
        if (last) begin
          // divide-by-zero forces q to all ones
          if (zero_q)      q_d = '1;
          else if (negq_q) q_d = -quo_n;
          else             q_d = quo_n;
          r_d  = negr_q ? -rem_n : rem_n;
          dz_d = zero_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      zero_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      zero_q <= zero_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dz_q   <= dz_d;
    end
  end

endmodule
